equation_scheduler: RTL and testbench

Session-level controller for the equation units of the alarm-dismissal game. It starts the equation datapaths one at a time in round-robin order and runs a per-equation seconds timer that it also feeds to the active unit. It aborts an equation whose answer does not arrive in time, tracks a streak of consecutive correct answers, and asserts Dismissed once the streak reaches the win target. It sits between the alarm/clock logic (Arm, Tick) and the NUM_EQ equation units.

---
 rtl/equation_scheduler.sv | 134 +++++++++++++
 tb/tb_equation_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/equation_scheduler.sv
// Session controller for the alarm-dismissal equation units: round-robin start,
// per-equation seconds timer with abort, correct-answer streak and score tracking.
module equation_scheduler #(
  parameter int         NUM_EQ     = 3,
  parameter logic [6:0] TIMEOUT    = 7'd60,
  parameter int         WIN_STREAK = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Arm,
  input  logic              Tick,
  input  logic [NUM_EQ-1:0] EqDone,
  input  logic [NUM_EQ-1:0] EqCorrect,
  output logic [NUM_EQ-1:0] EqStart,
  output logic              EqAbort,
  output logic [6:0]        OngoingTimer,
  output logic [1:0]        EqSel,
  output logic [2:0]        Streak,
  output logic [3:0]        Score,
  output logic              Busy,
  output logic              Dismissed
);

  localparam logic [2:0] WIN  = 3'(WIN_STREAK);
  localparam logic [1:0] LAST = 2'(NUM_EQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    EVAL,
    ABORT,
    DONE
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] sel_reg, sel_next;
  logic [6:0] timer_reg, timer_next;
  logic [2:0] streak_reg, streak_next;
  logic [3:0] score_reg, score_next;
  logic       correct_reg, correct_next;
  logic [1:0] sel_adv;

  assign sel_adv = (sel_reg == LAST) ? 2'd0 : sel_reg + 2'd1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg   <= IDLE;
      sel_reg     <= 2'd0;
      timer_reg   <= 7'd0;
      streak_reg  <= 3'd0;
      score_reg   <= 4'd0;
      correct_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      timer_reg   <= timer_next;
      streak_reg  <= streak_next;
      score_reg   <= score_next;
      correct_reg <= correct_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    timer_next   = timer_reg;
    streak_next  = streak_reg;
    score_next   = score_reg;
    correct_next = correct_reg;
    case (state_reg)
      IDLE: begin
        if (Arm) begin
          state_next  = START;
          streak_next = 3'd0;
          score_next  = 4'd0;
          timer_next  = 7'd0;
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        if (Tick && (timer_reg < TIMEOUT)) timer_next = timer_reg + 7'd1;
        // Abort is decided on the edge that registers the final tick, and only if no answer arrived.
        if (EqDone[sel_reg]) begin
          correct_next = EqCorrect[sel_reg];
          state_next   = EVAL;
        end else if (timer_next == TIMEOUT) begin
          state_next = ABORT;
        end
      end
      EVAL: begin
        if (correct_reg) begin
          streak_next = streak_reg + 3'd1;
          if (score_reg != 4'd15) score_next = score_reg + 4'd1;
          if (streak_reg + 3'd1 == WIN) begin
            state_next = DONE;
          end else begin
            state_next = START;
            sel_next   = sel_adv;
            timer_next = 7'd0;
          end
        end else begin
          streak_next = 3'd0;
          state_next  = START;
          sel_next    = sel_adv;
          timer_next  = 7'd0;
        end
      end
      ABORT: begin
        streak_next = 3'd0;
        state_next  = START;
        sel_next    = sel_adv;
        timer_next  = 7'd0;
      end
      DONE: begin
        if (!Arm) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < NUM_EQ; gi++) begin : g_start
    assign EqStart[gi] = (state_reg == START) && (sel_reg == 2'(gi));
  end

  assign EqAbort      = (state_reg == ABORT);
  assign OngoingTimer = timer_reg;
  assign EqSel        = sel_reg;
  assign Streak       = streak_reg;
  assign Score        = score_reg;
  assign Busy         = (state_reg != IDLE) && (state_reg != DONE);
  assign Dismissed    = (state_reg == DONE);

endmodule

// File: tb/tb_equation_scheduler.sv
// Directed bench: instance a (TIMEOUT=5, WIN_STREAK=3) and instance b
// (TIMEOUT=60, WIN_STREAK=7) share the same stimulus.
module tb_equation_scheduler;

  logic       clk = 1'b0;
  logic       rst, arm, tick;
  logic [2:0] done, corr;

  logic [2:0] a_start, b_start;
  logic       a_abort, b_abort, a_busy, b_busy, a_dis, b_dis;
  logic [6:0] a_timer, b_timer;
  logic [1:0] a_sel, b_sel;
  logic [2:0] a_streak, b_streak;
  logic [3:0] a_score, b_score;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  equation_scheduler #(.NUM_EQ(3), .TIMEOUT(7'd5), .WIN_STREAK(3)) dut_a (
    .Clock(clk), .Reset(rst), .Arm(arm), .Tick(tick), .EqDone(done), .EqCorrect(corr),
    .EqStart(a_start), .EqAbort(a_abort), .OngoingTimer(a_timer), .EqSel(a_sel),
    .Streak(a_streak), .Score(a_score), .Busy(a_busy), .Dismissed(a_dis)
  );

  equation_scheduler #(.NUM_EQ(3), .TIMEOUT(7'd60), .WIN_STREAK(7)) dut_b (
    .Clock(clk), .Reset(rst), .Arm(arm), .Tick(tick), .EqDone(done), .EqCorrect(corr),
    .EqStart(b_start), .EqAbort(b_abort), .OngoingTimer(b_timer), .EqSel(b_sel),
    .Streak(b_streak), .Score(b_score), .Busy(b_busy), .Dismissed(b_dis)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called in a START cycle: WAIT, answer, EVAL, then land in START/DONE.
  task automatic answer(input int unit, input logic ok);
    cyc(1);
    done = 3'b001 << unit;
    corr = ok ? done : 3'b000;
    cyc(1);
    done = 3'b000;
    corr = 3'b000;
    cyc(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(1);
    end
  endtask

  initial begin
    int exp_streak_tbl[6];
    int ok_tbl[6];
    int sc;
    int st;
    logic ok;
    exp_streak_tbl = '{1, 2, 0, 1, 2, 3};
    ok_tbl         = '{1, 1, 0, 1, 1, 1};
    rst = 1'b1; arm = 1'b0; tick = 1'b0; done = 3'b000; corr = 3'b000;

    // Reset state
    cyc(2);
    chk("reset_start", a_start, 0);
    chk("reset_abort", a_abort, 0);
    chk("reset_timer", a_timer, 0);
    chk("reset_sel", a_sel, 0);
    chk("reset_streak", a_streak, 0);
    chk("reset_score", a_score, 0);
    chk("reset_busy", a_busy, 0);
    chk("reset_dismissed", a_dis, 0);
    rst = 1'b0;
    cyc(1);
    chk("idle_no_arm_busy", a_busy, 0);

    // Win path
    arm = 1'b1;
    cyc(1);
    $display("txn arm: start=%b busy=%0d", a_start, a_busy);
    chk("win_start0", a_start, 3'b001);
    chk("win_busy", a_busy, 1);
    chk("win_timer0", a_timer, 0);
    answer(0, 1'b1);
    $display("txn answer unit0 ok: start=%b streak=%0d", a_start, a_streak);
    chk("win_start1", a_start, 3'b010);
    chk("win_streak1", a_streak, 1);
    chk("win_score1", a_score, 1);
    answer(1, 1'b1);
    $display("txn answer unit1 ok: start=%b streak=%0d", a_start, a_streak);
    chk("win_start2", a_start, 3'b100);
    chk("win_streak2", a_streak, 2);
    answer(2, 1'b1);
    $display("txn answer unit2 ok: dismissed=%0d score=%0d", a_dis, a_score);
    chk("win_dismissed", a_dis, 1);
    chk("win_done_busy", a_busy, 0);
    chk("win_streak3", a_streak, 3);
    chk("win_score3", a_score, 3);
    chk("win_done_start", a_start, 0);
    chk("win_done_sel", a_sel, 2);
    cyc(2);
    chk("win_hold_dismissed", a_dis, 1);
    arm = 1'b0;
    cyc(1);
    $display("txn drop arm: dismissed=%0d busy=%0d", a_dis, a_busy);
    chk("win_idle_dismissed", a_dis, 0);
    chk("win_idle_busy", a_busy, 0);

    // Wrong answer in the middle of a streak
    rst = 1'b1;
    cyc(1);
    rst = 1'b0; arm = 1'b1;
    cyc(1);
    chk("wrong_start0", a_start, 3'b001);
    for (int k = 0; k < 6; k++) begin
      answer(k % 3, ok_tbl[k] != 0);
      $display("txn eq%0d unit%0d ok=%0d: streak=%0d sel=%0d dis=%0d", k, k % 3, ok_tbl[k],
               a_streak, a_sel, a_dis);
      chk("wrong_streak", a_streak, exp_streak_tbl[k]);
      if (k < 5) begin
        chk("wrong_sel", a_sel, (k + 1) % 3);
        chk("wrong_not_dismissed", a_dis, 0);
      end
    end
    chk("wrong_dismissed", a_dis, 1);
    chk("wrong_score", a_score, 5);

    // Timeout (instance a, TIMEOUT=5)
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    answer(0, 1'b1);
    chk("to_streak_before", a_streak, 1);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    chk("to_tick_in_start_ignored", a_timer, 0);
    ticks(4);
    chk("to_timer4", a_timer, 4);
    chk("to_no_abort_yet", a_abort, 0);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    $display("txn 5th tick: timer=%0d abort=%0d", a_timer, a_abort);
    chk("to_timer5", a_timer, 5);
    chk("to_abort", a_abort, 1);
    chk("to_abort_no_start", a_start, 0);
    cyc(1);
    $display("txn after abort: start=%b timer=%0d streak=%0d", a_start, a_timer, a_streak);
    chk("to_abort_pulse_end", a_abort, 0);
    chk("to_next_start", a_start, 3'b100);
    chk("to_timer_cleared", a_timer, 0);
    chk("to_streak0", a_streak, 0);

    // Tick reaching TIMEOUT together with a correct answer
    cyc(1);
    ticks(4);
    tick = 1'b1; done = 3'b100; corr = 3'b100;
    cyc(1);
    tick = 1'b0; done = 3'b000; corr = 3'b000;
    $display("txn tick+done: timer=%0d abort=%0d", a_timer, a_abort);
    chk("sim_timer", a_timer, 5);
    chk("sim_no_abort", a_abort, 0);
    cyc(1);
    chk("sim_no_abort2", a_abort, 0);
    chk("sim_streak", a_streak, 1);
    chk("sim_start0", a_start, 3'b001);

    // EqDone on a non-selected unit is ignored
    cyc(1);
    done = 3'b010; corr = 3'b010;
    cyc(1);
    done = 3'b000; corr = 3'b000;
    cyc(1);
    $display("txn foreign done: start=%b sel=%0d streak=%0d", a_start, a_sel, a_streak);
    chk("foreign_no_start", a_start, 0);
    chk("foreign_sel", a_sel, 0);
    chk("foreign_streak", a_streak, 1);
    done = 3'b001; corr = 3'b001;
    cyc(1);
    done = 3'b000; corr = 3'b000;
    cyc(1);
    chk("foreign_then_real_start", a_start, 3'b010);
    chk("foreign_then_real_streak", a_streak, 2);

    // Reset mid-WAIT (instance b, TIMEOUT=60)
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("rst_b_start0", b_start, 3'b001);
    answer(0, 1'b1);
    answer(1, 1'b1);
    cyc(1);
    ticks(17);
    $display("txn before reset: timer=%0d streak=%0d", b_timer, b_streak);
    chk("rst_b_timer17", b_timer, 17);
    chk("rst_b_streak2", b_streak, 2);
    rst = 1'b1;
    cyc(1);
    $display("txn mid-wait reset: timer=%0d streak=%0d abort=%0d", b_timer, b_streak, b_abort);
    chk("rst_b_start", b_start, 0);
    chk("rst_b_abort", b_abort, 0);
    chk("rst_a_abort", a_abort, 0);
    chk("rst_b_timer", b_timer, 0);
    chk("rst_b_sel", b_sel, 0);
    chk("rst_b_streak", b_streak, 0);
    chk("rst_b_score", b_score, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_b_dismissed", b_dis, 0);
    rst = 1'b0;
    cyc(1);
    chk("rst_b_restart", b_start, 3'b001);
    chk("rst_b_restart_sel", b_sel, 0);

    // Score saturation (instance b, WIN_STREAK=7)
    sc = 0;
    st = 0;
    for (int k = 0; k < 40; k++) begin
      ok = ((k % 2) == 0);
      answer(k % 3, ok);
      if (ok) begin
        sc = (sc < 15) ? sc + 1 : 15;
        st = st + 1;
      end else begin
        st = 0;
      end
      $display("txn sat eq%0d ok=%0d: score=%0d streak=%0d", k, ok, b_score, b_streak);
      chk("sat_score", b_score, sc);
      chk("sat_streak", b_streak, st);
      chk("sat_sel", b_sel, (k + 1) % 3);
    end
    chk("sat_not_dismissed", b_dis, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
